// File: rtl/i2c_slave_byte_engine.sv
// I2C slave byte engine: synchronizes the raw bus, matches a 7-bit address and
// moves bytes in both directions with ACK handling, exposing its FSM state.
module i2c_slave_byte_engine #(
  parameter logic [6:0] DEV_ADDR = 7'h2A
) (
  input  logic       clk_sys,
  input  logic       rst_neg,
  input  logic       scl,
  input  logic       sda_in,
  input  logic       start_detect,
  input  logic       stop_detect,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rw,
  output logic       busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR       = 3'd3,
    WR_ACK   = 3'd4,
    RD       = 3'd5,
    RD_ACK   = 3'd6,
    WAIT     = 3'd7
  } state_t;

  state_t      state;
  logic [1:0]  scl_sync, sda_sync, sta_sync, sto_sync;
  logic        scl_d, sta_d, sto_d;
  logic        scl_rise, scl_fall, start_rise, stop_rise, sda_s;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        ack_clk;

  always_ff @(posedge clk_sys or negedge rst_neg) begin
    if (!rst_neg) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      sta_sync <= 2'b00;
      sto_sync <= 2'b00;
      scl_d    <= 1'b1;
      sta_d    <= 1'b0;
      sto_d    <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
      sta_sync <= {sta_sync[0], start_detect};
      sto_sync <= {sto_sync[0], stop_detect};
      scl_d    <= scl_sync[1];
      sta_d    <= sta_sync[1];
      sto_d    <= sto_sync[1];
    end
  end

  assign scl_rise   = scl_sync[1] & ~scl_d;
  assign scl_fall   = ~scl_sync[1] & scl_d;
  assign start_rise = sta_sync[1] & ~sta_d;
  assign stop_rise  = sto_sync[1] & ~sto_d;
  assign sda_s      = sda_sync[1];

  // ack_clk marks that the 9th (ACK) scl rise of the current byte has been seen,
  // so the following fall releases the ACK instead of asserting it.
  always_ff @(posedge clk_sys or negedge rst_neg) begin
    if (!rst_neg) begin
      state    <= IDLE;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      rw       <= 1'b0;
      bit_cnt  <= 4'd0;
      shift    <= 8'h00;
      ack_clk  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (start_rise) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        ack_clk <= 1'b0;
      end else if (stop_rise) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          ADDR, WR: begin
            if (scl_rise) begin
              shift <= {shift[6:0], sda_s};
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd8;
                ack_clk <= 1'b0;
                if (state == ADDR) begin
                  rw    <= sda_s;
                  state <= (shift[6:0] == DEV_ADDR) ? ADDR_ACK : WAIT;
                end else begin
                  rx_data  <= {shift[6:0], sda_s};
                  rx_valid <= 1'b1;
                  state    <= WR_ACK;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ADDR_ACK, WR_ACK: begin
            if (scl_fall) begin
              if (!ack_clk) begin
                sda_oe <= 1'b1;
              end else begin
                bit_cnt <= 4'd0;
                ack_clk <= 1'b0;
                if (state == ADDR_ACK && rw) begin
                  shift  <= tx_data;
                  sda_oe <= ~tx_data[7];
                  state  <= RD;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= WR;
                end
              end
            end else if (scl_rise) begin
              ack_clk <= 1'b1;
              if (state == ADDR_ACK && rw) tx_req <= 1'b1;
            end
          end
          RD: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                ack_clk <= 1'b0;
                state   <= RD_ACK;
              end else begin
                shift  <= {shift[6:0], 1'b0};
                sda_oe <= ~shift[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                tx_req  <= 1'b1;
                ack_clk <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end else if (scl_fall && ack_clk) begin
              bit_cnt <= 4'd0;
              ack_clk <= 1'b0;
              shift   <= tx_data;
              sda_oe  <= ~tx_data[7];
              state   <= RD;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_i2c_slave_byte_engine.sv
// Bench for i2c_slave_byte_engine: bit-banged I2C master, table of whole
// transactions, randomized transactions against a transaction-level model.
module tb_i2c_slave_byte_engine;

  localparam logic [6:0] DEV = 7'h2A;
  localparam int H = 8;
  localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_WAIT = 3'd7;

  logic       clk_sys = 1'b0;
  logic       rst_neg = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       start_detect = 1'b0;
  logic       stop_detect = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sda_oe, rx_valid, tx_req, rw, busy;
  logic [7:0] rx_data;
  logic [2:0] state_dbg;
  logic       sda_bus;

  // Open-drain bus: either side pulling low wins.
  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_byte_engine #(.DEV_ADDR(DEV)) dut (
    .clk_sys(clk_sys), .rst_neg(rst_neg), .scl(scl), .sda_in(sda_bus),
    .start_detect(start_detect), .stop_detect(stop_detect), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
    .rw(rw), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_pass = 0;
  int rx_cnt = 0;
  int treq_cnt = 0;
  logic oe_seen = 1'b0;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] tx_src[$];

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    int         nbytes;
    logic [7:0] d0, d1, d2;
    logic       exp_ack;
    int         exp_rx;
    int         exp_treq;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Scoreboard and tx_data supplier.
  always @(negedge clk_sys) begin
    if (rst_neg) begin
      if (sda_oe) oe_seen = 1'b1;
      if (rx_valid) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rx_unexpected: got rx_valid data %0h expected none", rx_data);
        end else begin
          check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (tx_req) begin
        treq_cnt++;
        if (tx_src.size() != 0) tx_data = tx_src.pop_front();
      end
    end
  end

  task automatic do_start;
    sda_m = 1'b1; wait_clk(H);
    scl = 1'b1;   wait_clk(H);
    sda_m = 1'b0; start_detect = 1'b1; wait_clk(4);
    start_detect = 1'b0; wait_clk(H);
    scl = 1'b0;   wait_clk(H);
  endtask

  task automatic do_stop;
    sda_m = 1'b0; wait_clk(H);
    scl = 1'b1;   wait_clk(H);
    sda_m = 1'b1; stop_detect = 1'b1; wait_clk(4);
    stop_detect = 1'b0; wait_clk(H);
  endtask

  task automatic clock_bit(input logic b, output logic seen);
    sda_m = b; wait_clk(H);
    scl = 1'b1; wait_clk(H);
    seen = sda_bus;
    scl = 1'b0; wait_clk(H);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack_low);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(v[i], s);
    clock_bit(1'b1, s);
    ack_low = ~s;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      v[i] = s;
    end
    clock_bit(nack, s);
  endtask

  // Transaction-level model: a matching address is ACKed and every byte moves;
  // anything else is ignored and the bus stays released.
  task automatic run_txn(input logic [6:0] a, input logic r, input int n,
                         input logic [7:0] d0, d1, d2, output logic addr_ack);
    logic [7:0] d[3];
    logic       match, ack;
    logic [7:0] v;
    d[0] = d0; d[1] = d1; d[2] = d2;
    match = (a == DEV);
    rx_cnt = 0; treq_cnt = 0; oe_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (match && !r) begin exp_q.push_back(d[i]); last_rx = d[i]; end
      if (match && r) tx_src.push_back(d[i]);
    end
    do_start;
    send_byte({a, r}, ack);
    addr_ack = ack;
    check("addr_ack", {31'h0, ack}, {31'h0, match});
    if (!match) check("state_wait", {29'h0, state_dbg}, {29'h0, S_WAIT});
    for (int i = 0; i < n; i++) begin
      if (!r) begin
        send_byte(d[i], ack);
        check("data_ack", {31'h0, ack}, {31'h0, match});
      end else begin
        recv_byte(i == n - 1, v);
        check("rd_byte", {24'h0, v}, {24'h0, match ? d[i] : 8'hFF});
      end
    end
    do_stop;
    check("busy_after_stop", {31'h0, busy}, 32'h0);
    check("oe_seen", {31'h0, oe_seen}, {31'h0, match});
    check("rx_data_hold", {24'h0, rx_data}, {24'h0, last_rx});
    check("exp_q_drained", exp_q.size(), 0);
    tx_src.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] v;
    logic [6:0] ra;
    logic       rr;
    int         rn;

    vecs[0] = '{DEV,   1'b0, 1, 8'hA5, 8'h00, 8'h00, 1'b1, 1, 0};
    vecs[1] = '{DEV,   1'b1, 2, 8'h3C, 8'hC3, 8'h00, 1'b1, 0, 2};
    vecs[2] = '{7'h15, 1'b0, 2, 8'h11, 8'h22, 8'h00, 1'b0, 0, 0};
    vecs[3] = '{DEV,   1'b0, 3, 8'h00, 8'hFF, 8'h5A, 1'b1, 3, 0};
    vecs[4] = '{7'h2B, 1'b1, 1, 8'h77, 8'h00, 8'h00, 1'b0, 0, 0};

    wait_clk(3);
    check("rst_sda_oe", {31'h0, sda_oe}, 32'h0);
    check("rst_rx_data", {24'h0, rx_data}, 32'h0);
    check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_tx_req", {31'h0, tx_req}, 32'h0);
    check("rst_rw", {31'h0, rw}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst_neg = 1'b1;
    wait_clk(4);

    for (int k = 0; k < 5; k++) begin
      run_txn(vecs[k].addr, vecs[k].rw, vecs[k].nbytes, vecs[k].d0, vecs[k].d1, vecs[k].d2, ack);
      check("tbl_addr_ack", {31'h0, ack}, {31'h0, vecs[k].exp_ack});
      check("tbl_rx_cnt", rx_cnt, vecs[k].exp_rx);
      check("tbl_treq_cnt", treq_cnt, vecs[k].exp_treq);
    end

    for (int k = 0; k < 10; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : DEV;
      rr = 1'($urandom_range(0, 1));
      rn = $urandom_range(1, 3);
      run_txn(ra, rr, rn, 8'($urandom), 8'($urandom), 8'($urandom), ack);
      check("rnd_rx_cnt", rx_cnt, (ra == DEV && !rr) ? rn : 0);
      check("rnd_treq_cnt", treq_cnt, (ra == DEV && rr) ? rn : 0);
    end

    // Repeated START in the middle of a write byte: partial byte is dropped.
    rx_cnt = 0; treq_cnt = 0;
    do_start;
    send_byte({DEV, 1'b0}, ack);
    check("rs_addr_ack", {31'h0, ack}, 32'h1);
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), ack);
    tx_src.push_back(8'h96);
    do_start;
    send_byte({DEV, 1'b1}, ack);
    check("rs_read_ack", {31'h0, ack}, 32'h1);
    check("rs_rw", {31'h0, rw}, 32'h1);
    recv_byte(1'b1, v);
    check("rs_rd_byte", {24'h0, v}, 32'h96);
    do_stop;
    check("rs_rx_cnt", rx_cnt, 0);
    check("rs_treq_cnt", treq_cnt, 1);
    check("rs_rx_hold", {24'h0, rx_data}, {24'h0, last_rx});

    // START and STOP edges in the same cycle: START wins.
    start_detect = 1'b1; stop_detect = 1'b1; wait_clk(4);
    start_detect = 1'b0; stop_detect = 1'b0; wait_clk(2);
    check("ss_state", {29'h0, state_dbg}, {29'h0, S_ADDR});
    check("ss_busy", {31'h0, busy}, 32'h1);
    sda_m = 1'b1;
    stop_detect = 1'b1; wait_clk(4); stop_detect = 1'b0; wait_clk(4);
    check("ss_stop_busy", {31'h0, busy}, 32'h0);

    // Reset while driving a 0 data bit on a read.
    tx_src.delete();
    tx_src.push_back(8'h00);
    do_start;
    send_byte({DEV, 1'b1}, ack);
    check("rst_pre_oe", {31'h0, sda_oe}, 32'h1);
    @(negedge clk_sys);
    #2 rst_neg = 1'b0;
    #1;
    check("rst_async_oe", {31'h0, sda_oe}, 32'h0);
    check("rst_async_busy", {31'h0, busy}, 32'h0);
    check("rst_async_rw", {31'h0, rw}, 32'h0);
    check("rst_async_rx", {24'h0, rx_data}, 32'h0);
    check("rst_async_state", {29'h0, state_dbg}, {29'h0, S_IDLE});
    check("rst_async_pulses", {30'h0, rx_valid, tx_req}, 32'h0);
    scl = 1'b1; sda_m = 1'b1;
    exp_q.delete(); tx_src.delete(); last_rx = 8'h00;
    wait_clk(3);
    rst_neg = 1'b1;
    oe_seen = 1'b0;
    for (int i = 0; i < 10; i++) clock_bit(1'($urandom_range(0, 1)), ack);
    check("post_rst_busy", {31'h0, busy}, 32'h0);
    check("post_rst_oe", {31'h0, oe_seen}, 32'h0);
    run_txn(DEV, 1'b0, 1, 8'h5C, 8'h00, 8'h00, ack);
    check("post_rst_rx_cnt", rx_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_slave_byte_engine.md
I2C_SLAVE_BYTE_ENGINE -- requirements
Module: i2c_slave_byte_engine

Interface
REQ-001 Parameter SHALL be: DEV_ADDR, 7'h2A, 7-bit slave address matched after START.
REQ-002 clk_sys  input  1  system clock; all logic rising-edge clocked except reset.
REQ-003 rst_neg  input  1  reset rst_neg, asynchronous, active-low.
REQ-004 scl  input  1  raw I2C clock, asynchronous to clk_sys.
REQ-005 sda_in  input  1  raw I2C data, asynchronous to clk_sys.
REQ-006 start_detect  input  1  asynchronous START flag from upstream start/stop detector.
REQ-007 stop_detect  input  1  asynchronous STOP flag from upstream start/stop detector.
REQ-008 sda_oe  output  1  open-drain enable; 1 = pull SDA low.
REQ-009 rx_data  output  8  last byte written by master.
REQ-010 rx_valid  output  1  one-clk_sys pulse, rx_data updated.
REQ-011 tx_data  input  8  byte to return on master read.
REQ-012 tx_req  output  1  one-clk_sys pulse, tx_data required.
REQ-013 rw  output  1  R/W bit of current transaction (1 = read).
REQ-014 busy  output  1  high in any state except IDLE.

Function
REQ-015 scl, sda_in, start_detect, stop_detect SHALL each pass a 2-FF synchronizer, then one edge register; edge pulses are 1 clk_sys wide.
REQ-016 Rising edge of synced start_detect SHALL force state ADDR, bit counter 0, sda_oe 0, from any state (repeated START).
REQ-017 Rising edge of synced stop_detect SHALL force IDLE, sda_oe 0; same-cycle START and STOP edges: START wins.
REQ-018 States SHALL be: IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT.
REQ-019 Data SHALL be sampled on scl rising-edge pulse, MSB first; sda_oe SHALL change only on scl falling-edge pulse (or START/STOP/reset).
REQ-020 ADDR: after 8th scl rise, bits[7:1] compared with DEV_ADDR, bit[0] latched to rw; match -> ADDR_ACK; mismatch -> WAIT, sda_oe never asserted.
REQ-021 ADDR_ACK: sda_oe=1 from next scl fall to the following scl fall; on 9th scl rise, if rw=1 pulse tx_req; on release fall go WR (rw=0) or RD (rw=1).
REQ-022 RD: tx_data latched into shift register on the scl fall entering RD; sda_oe = ~bit for each of 8 bits.
REQ-023 After 8th RD bit, next scl fall SHALL release sda_oe and enter RD_ACK; on 9th scl rise sample sda_in: 0 (ACK) -> pulse tx_req, next fall re-enter RD; 1 (NACK) -> WAIT.
REQ-024 WR: after 8th scl rise, rx_data updated and rx_valid pulsed same clk_sys cycle; -> WR_ACK, ACK driven as REQ-021, then WR.
REQ-025 WAIT: sda_oe 0, all scl ignored; exits only by START, STOP or reset.
REQ-026 Bit counter 4 bits, 0..8, cleared on START and on every ACK-release fall; no wrap beyond 8.
REQ-027 STOP or START mid-byte SHALL discard partial byte: no rx_valid, no tx_req.
REQ-028 rx_data SHALL hold last value until next completed write byte.

Reset
REQ-029 On rst_neg low: state IDLE, sda_oe 0, rx_data 8'h00, rx_valid 0, tx_req 0, rw 0, busy 0, synchronizers cleared to scl=1, sda_in=1, flags=0.
REQ-030 Reset assertion mid-transaction SHALL release SDA immediately (asynchronous), without waiting for clk_sys.
REQ-031 After release, block SHALL ignore bus until next START edge.

Verification
REQ-032 START, addr 0x2A+W, data 0xA5, STOP -> ACK on 9th clocks of both bytes, rx_valid once, rx_data=0xA5, busy low after STOP.
REQ-033 START, addr 0x2A+R, tx_data=0x3C then 0xC3, master ACK then NACK, STOP -> SDA reads 0x3C, 0xC3; tx_req pulses exactly twice.
REQ-034 START, addr 0x15+W, 2 bytes -> sda_oe never 1, rx_valid never, state WAIT until STOP.
REQ-035 START, 0x2A+W, 4 bits of data, repeated START, 0x2A+R -> no rx_valid, rw=1, read proceeds normally.
REQ-036 rst_neg low during RD while sda_oe=1 -> sda_oe 0 same instant, all outputs at REQ-029 values.
REQ-037 START and STOP edges in same clk_sys cycle -> state ADDR, busy 1.
